psum_accum: RTL and testbench

Downstream stage of the 4-lane processing element. It accumulates the PE's 16-bit dot-product results over a variable number of chunks, which together form one output pixel. Each finished pixel is saturated and, optionally, rectified, then buffered in a small FIFO and handed to the output writer over valid/ready. The PE carries no valid signal and cannot stall, so this block does two jobs for it:
- tracks issue timing with a delay line;
- grants issue credit to the upstream operand feeder so that no PE result is ever dropped.

---
 rtl/pe_pkg.sv | 40 ++++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/psum_accum.sv | 129 ++++++++++++
 tb/tb_psum_accum.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the processing-element output path.
//   DW_DEF / AW_DEF : default result width and accumulator width
//   SAT_MAX/SAT_MIN : signed DW-bit range, held at accumulator width
//   pix_t           : one finished pixel {sat_flag, data}
//   sat()           : clamps an accumulator value into the DW range and
//                     reports whether clipping happened
// No ports (package).
// -----------------------------------------------------------------------------
package pe_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 32;

    localparam logic signed [AW_DEF-1:0] SAT_MAX = AW_DEF'((1 << (DW_DEF - 1)) - 1);
    localparam logic signed [AW_DEF-1:0] SAT_MIN = ~SAT_MAX;

    typedef struct packed {
        logic              sat_flag;
        logic [DW_DEF-1:0] data;
    } pix_t;

    // Clamp a wide signed sum into the DW range; sat_flag marks a clipped value.
    function automatic pix_t sat(input logic signed [AW_DEF-1:0] value);
        pix_t result;
        if (value > SAT_MAX) begin
            result.sat_flag = 1'b1;
            result.data     = SAT_MAX[DW_DEF-1:0];
        end else if (value < SAT_MIN) begin
            result.sat_flag = 1'b1;
            result.data     = SAT_MIN[DW_DEF-1:0];
        end else begin
            result.sat_flag = 1'b0;
            result.data     = value[DW_DEF-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a first-word fall-through head and a registered
// occupancy count. The head reads as zero while the FIFO is empty.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge (the popped slot is the one being overwritten).
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   push, push_data : write request and data
//   pop             : consume the head entry (ignored when empty)
//   head            : current head entry
//   not_empty       : head holds a valid entry
//   count           : number of stored entries (registered)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   not_empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Flags, qualified handshakes and the fall-through head.
    always_comb begin
        not_empty = (count != '0);
        full      = (count == FULL_COUNT);
        do_pop    = pop && not_empty;
        do_push   = push && (!full || do_pop);
        head      = not_empty ? mem[rd_ptr] : '0;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/psum_accum.sv
// -----------------------------------------------------------------------------
// psum_accum
// Accumulates PE dot-product chunks into output pixels, saturates each
// finished pixel, buffers it and hands it downstream over valid/ready.
// The PE has no valid and cannot stall, so a PE_LAT-deep {valid,last} delay
// line marks which pe_result samples are real, and issue credit is granted
// only while every issued last already has a FIFO slot reserved.
// Optional build macro:
//   RELU_EN : negative saturated pixels are replaced by 0 (sat_flag unchanged)
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   issue_valid  : feeder presents an operand set to the PE
//   issue_last   : that operand set closes the current pixel
//   issue_ready  : feeder may issue this cycle
//   pe_result    : signed PE result, PE_LAT cycles after its issue
//   out_valid    : out_data / sat_flag hold a finished pixel
//   out_ready    : downstream accepts the pixel
//   out_data     : saturated pixel value (signed)
//   sat_flag     : pixel was clipped
//   err          : sticky, an issue arrived without credit
// -----------------------------------------------------------------------------
module psum_accum
    import pe_pkg::*;
#(
    parameter int PE_LAT     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = DW_DEF,
    parameter int AW         = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic          issue_last,
    output logic          issue_ready,
    input  logic [DW-1:0] pe_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          sat_flag,
    output logic          err
);

    localparam int CW = $clog2(FIFO_DEPTH + PE_LAT + 1);

    logic [PE_LAT-1:0]             dl_valid;
    logic [PE_LAT-1:0]             dl_last;
    logic                          issue_ok;
    logic                          beat_valid;
    logic                          beat_last;
    logic [CW-1:0]                 lasts_in_flight;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic signed [AW-1:0]          acc;
    logic signed [AW-1:0]          acc_next;
    logic signed [AW-1:0]          pe_ext;
    logic                          first;
    pix_t                          pix_in;
    pix_t                          head_pix;

    // Credit: lasts still travelling through the PE plus stored pixels must
    // stay below the FIFO depth. Both terms come from registers only.
    always_comb begin
        lasts_in_flight = '0;
        for (int i = 0; i < PE_LAT; i++) begin
            lasts_in_flight = lasts_in_flight + CW'(dl_valid[i] & dl_last[i]);
        end
        issue_ready = (CW'(fifo_count) + lasts_in_flight) < CW'(FIFO_DEPTH);
        issue_ok    = issue_valid & issue_ready;
        beat_valid  = dl_valid[PE_LAT-1];
        beat_last   = dl_last[PE_LAT-1];
    end

    // Delay line whose tail lines up with pe_result; illegal issues never enter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dl_valid <= '0;
            dl_last  <= '0;
        end else begin
            dl_valid <= (dl_valid << 1) | PE_LAT'(issue_ok);
            dl_last  <= (dl_last << 1) | PE_LAT'(issue_last);
        end
    end

    // Next accumulator value and the saturated (optionally rectified) pixel.
    always_comb begin
        pe_ext   = {{(AW - DW){pe_result[DW-1]}}, pe_result};
        acc_next = (first ? '0 : acc) + pe_ext;
        pix_in   = sat(acc_next);
`ifdef RELU_EN
        if (pix_in.data[DW_DEF-1]) begin
            pix_in.data = '0;
        end
`endif
    end

    // Accumulator, start-of-pixel marker and the sticky protocol error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            first <= 1'b1;
            err   <= 1'b0;
        end else begin
            if (issue_valid && !issue_ready) begin
                err <= 1'b1;
            end
            if (beat_valid) begin
                acc   <= acc_next;
                first <= beat_last;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (beat_valid & beat_last),
        .push_data (pix_in),
        .pop       (out_valid & out_ready),
        .head      (head_pix),
        .not_empty (out_valid),
        .count     (fifo_count)
    );

    assign out_data = head_pix.data;
    assign sat_flag = head_pix.sat_flag;

endmodule

// File: tb/tb_psum_accum.sv
// -----------------------------------------------------------------------------
// tb_psum_accum
// Scoreboard bench for psum_accum. The driver feeds chunks, models the PE as
// a pure PE_LAT-cycle delay of the chunk values, and computes each expected
// pixel from the running sum of accepted chunks. Expected pixels go into a
// queue with the cycle they become visible; a separate monitor compares them
// whenever the DUT presents a pixel. Issue credit is modelled as
// "issued lasts not yet popped < FIFO_DEPTH".
// -----------------------------------------------------------------------------
module tb_psum_accum;

    localparam int PE_LAT     = 4;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        int data;
        bit flag;
        int avail;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] pe_result = '0;
    logic        issue_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        sat_flag;
    logic        err;

    exp_t        sb[$];
    logic [15:0] hist [PE_LAT];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lasts_issued = 0;
    int          pop_applied = 0;
    int          pop_total = 0;
    int          model_acc = 0;
    bit          model_err = 1'b0;

    psum_accum #(
        .PE_LAT     (PE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_last  (issue_last),
        .issue_ready (issue_ready),
        .pe_result   (pe_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .sat_flag    (sat_flag),
        .err         (err)
    );

    // Free-running clock and cycle counter used for latency expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input integer act, input integer expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit modelReady();
        return (lasts_issued - pop_applied) < FIFO_DEPTH;
    endfunction

    // Saturate and optionally rectify a finished sum, then queue it.
    task automatic pushExpected(input int sum);
        int d;
        bit f;
        if (sum > 32767) begin
            d = 32767;
            f = 1'b1;
        end else if (sum < -32768) begin
            d = -32768;
            f = 1'b1;
        end else begin
            d = sum;
            f = 1'b0;
        end
`ifdef RELU_EN
        if (d < 0) d = 0;
`endif
        sb.push_back('{data: d, flag: f, avail: cyc + 1 + PE_LAT});
    endtask

    // One cycle of stimulus: check credit/err, drive inputs, update model.
    task automatic applyStimulus(input bit v, input bit l, input int val, input bit rdy);
        bit          exp_ready;
        logic [15:0] drive_val;
        exp_ready = modelReady();
        checkOutput("issue_ready", issue_ready, exp_ready);
        checkOutput("err", err, model_err);
        drive_val   = v ? 16'(val) : 16'($urandom);
        issue_valid = v;
        issue_last  = l;
        out_ready   = rdy;
        pe_result   = hist[PE_LAT-1];
        if (v && exp_ready) begin
            model_acc = model_acc + val;
            if (l) begin
                pushExpected(model_acc);
                model_acc = 0;
                lasts_issued++;
            end
        end else if (v) begin
            model_err = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int k = PE_LAT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0]     = drive_val;
        pop_applied = pop_total;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 0, rdy);
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        model_acc    = 0;
        model_err    = 1'b0;
        lasts_issued = 0;
        pop_applied  = 0;
        rst_n        = 1'b1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_sat_flag", sat_flag, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_issue_ready", issue_ready, 1);
    endtask

    // Monitor: compares the queue head with whatever the DUT presents.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            pop_total = 0;
        end else begin
            bit exp_v;
            exp_v = (sb.size() > 0) && (sb[0].avail <= cyc);
            checkOutput("out_valid", out_valid, exp_v);
            if (out_valid && exp_v) begin
                checkOutput("out_data", $signed(out_data), sb[0].data);
                checkOutput("sat_flag", sat_flag, sb[0].flag);
            end
            if (exp_v && out_ready) begin
                void'(sb.pop_front());
                pop_total++;
            end
        end
    end

    initial begin
        int issued;
        for (int k = 0; k < PE_LAT; k++) hist[k] = '0;
        doReset();

        $display("[TB] single-chunk pixels");
        applyStimulus(1, 1, 5, 1);
        applyStimulus(1, 1, -3, 1);
        applyStimulus(1, 1, 100, 1);
        idle(PE_LAT + 3, 1);

        $display("[TB] multi-chunk pixel");
        applyStimulus(1, 0, 1000, 1);
        applyStimulus(1, 0, 2000, 1);
        applyStimulus(1, 0, -500, 1);
        applyStimulus(1, 1, 7, 1);
        idle(PE_LAT + 3, 1);

        $display("[TB] saturation");
        for (int i = 0; i < 3; i++) applyStimulus(1, i == 2, 20000, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, i == 2, -20000, 1);
        idle(PE_LAT + 3, 1);

        $display("[TB] backpressure and illegal issue");
        issued = 0;
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            if (modelReady()) begin
                applyStimulus(1, 1, 10 + issued, 0);
                issued++;
            end else begin
                idle(1, 0);
            end
        end
        checkOutput("issued_before_stall", issued, FIFO_DEPTH);
        idle(PE_LAT + 4, 0);
        applyStimulus(1, 1, 777, 0);
        idle(2, 0);
        for (int b = 0; b < 200 && issued < FIFO_DEPTH + 2; b++) begin
            if (modelReady()) begin
                applyStimulus(1, 1, 10 + issued, 1);
                issued++;
            end else begin
                idle(1, 1);
            end
        end
        checkOutput("issued_after_release", issued, FIFO_DEPTH + 2);
        idle(PE_LAT + 8, 1);

        $display("[TB] reset mid-pixel");
        applyStimulus(1, 0, 50, 1);
        applyStimulus(1, 0, 60, 1);
        doReset();
        applyStimulus(1, 1, 9, 1);
        idle(PE_LAT + 3, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit l;
            bit rdy;
            int val;
            v   = ($urandom_range(0, 3) != 0);
            l   = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            val = int'($urandom_range(0, 65535)) - 32768;
            if (!modelReady() && $urandom_range(0, 19) != 0) v = 1'b0;
            applyStimulus(v, l, val, rdy);
        end
        for (int i = 0; i < 200 && (sb.size() > 0 || i < PE_LAT + 2); i++) idle(1, 1);
        checkOutput("drain_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
